tf_sched: RTL and testbench

Stage-by-stage scheduler for the NTT twiddle-factor path. It fetches per-stage twiddle parameters (base, step, length) and sequences a shared pipelined modular multiplier to generate w_k = base·step^k mod q. Twiddles are streamed to the butterfly array over a valid/ready handshake. It sits between the stage-parameter store, the external MulMod instance and the butterfly consumers, replacing ad-hoc TF_wen/TF_ren sequencing.

---
 rtl/tf_sched.sv | 204 ++++++++++++++++++++
 tb/tb_tf_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_sched.sv
// tf_sched: per-stage twiddle-factor scheduler for the NTT datapath.
// Fetches (base, step, len) for each stage, drives a shared pipelined
// modular multiplier to form w_k = base*step^k mod q, and streams the
// twiddles out over a valid/ready handshake.
module tf_sched #(
    parameter int DW      = 32,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 12,
    parameter int SW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    modulus,
    input  logic [SW-1:0]    num_stages,
    output logic             busy,
    output logic             done,
    output logic             prm_req,
    output logic [SW-1:0]    prm_stage,
    input  logic             prm_ack,
    input  logic [DW-1:0]    prm_base,
    input  logic [DW-1:0]    prm_step,
    input  logic [CNT_W-1:0] prm_len,
    output logic             mul_vld,
    output logic [DW-1:0]    mul_a,
    output logic [DW-1:0]    mul_b,
    output logic [DW-1:0]    mul_mod,
    input  logic [DW-1:0]    mul_res,
    output logic             tf_vld,
    input  logic             tf_rdy,
    output logic [DW-1:0]    tf_data,
    output logic [CNT_W-1:0] tf_idx,
    output logic [SW-1:0]    tf_stage
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_WAIT, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [DW-1:0]      r_mod, r_step, r_cur, r_nxt;
    logic [SW-1:0]      r_nstages, r_stage;
    logic [CNT_W-1:0]   r_len, r_idx;
    logic               r_nxt_vld;   // product for idx+1 already captured
    logic               r_issued;    // multiply for the current idx already issued
    logic [MUL_LAT-1:0] r_vsr;       // in-flight multiply tracker

    logic w_res_vld, w_last_idx, w_last_stage, w_issue, w_have_nxt;

    // mul_res is only trusted in the cycle its issue strobe has aged MUL_LAT cycles
    assign w_res_vld    = r_vsr[MUL_LAT-1];
    // len is never 0 in EMIT/WAIT (checked at fetch), so len-1 cannot wrap here
    assign w_last_idx   = (r_idx == r_len - CNT_W'(1));
    assign w_last_stage = (r_stage == r_nstages - SW'(1));
    assign w_issue      = (r_state == S_EMIT) && !r_issued && (r_idx < r_len - CNT_W'(1));
    // a result landing in the handshake cycle is used directly instead of waiting
    assign w_have_nxt   = r_nxt_vld || w_res_vld;
    assign mul_mod      = r_mod;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-driven outputs
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        prm_req      = 1'b0;
        prm_stage    = '0;
        mul_vld      = 1'b0;
        mul_a        = '0;
        mul_b        = '0;
        tf_vld       = 1'b0;
        tf_data      = '0;
        tf_idx       = '0;
        tf_stage     = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_stages == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                prm_req   = 1'b1;
                prm_stage = r_stage;
                if (prm_ack) begin
                    if (prm_len == '0) begin
                        w_state_next = w_last_stage ? S_DONE : S_FETCH;
                    end else begin
                        w_state_next = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                tf_vld   = 1'b1;
                tf_data  = r_cur;
                tf_idx   = r_idx;
                tf_stage = r_stage;
                if (w_issue) begin
                    mul_vld = 1'b1;
                    mul_a   = r_cur;
                    mul_b   = r_step;
                end
                if (tf_rdy) begin
                    if (w_last_idx) begin
                        w_state_next = w_last_stage ? S_DONE : S_FETCH;
                    end else if (!w_have_nxt) begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_res_vld) begin
                    w_state_next = S_EMIT;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Issue-age shift register; cleared on reset so in-flight products are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsr <= '0;
        end else begin
            r_vsr <= (r_vsr << 1) | MUL_LAT'(mul_vld);
        end
    end

    // Datapath: transform config, stage parameters, current/next twiddle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mod     <= '0;
            r_nstages <= '0;
            r_stage   <= '0;
            r_step    <= '0;
            r_len     <= '0;
            r_cur     <= '0;
            r_nxt     <= '0;
            r_idx     <= '0;
            r_nxt_vld <= 1'b0;
            r_issued  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mod     <= modulus;
                        r_nstages <= num_stages;
                        r_stage   <= '0;
                    end
                end
                S_FETCH: begin
                    if (prm_ack) begin
                        r_step    <= prm_step;
                        r_len     <= prm_len;
                        r_cur     <= prm_base;
                        r_idx     <= '0;
                        r_issued  <= 1'b0;
                        r_nxt_vld <= 1'b0;
                        if (prm_len == '0 && !w_last_stage) begin
                            r_stage <= r_stage + SW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (w_issue) begin
                        r_issued <= 1'b1;
                    end
                    if (w_res_vld) begin
                        r_nxt     <= mul_res;
                        r_nxt_vld <= 1'b1;
                    end
                    if (tf_rdy) begin
                        if (w_last_idx) begin
                            if (!w_last_stage) begin
                                r_stage <= r_stage + SW'(1);
                            end
                        end else if (w_have_nxt) begin
                            r_cur     <= r_nxt_vld ? r_nxt : mul_res;
                            r_idx     <= r_idx + CNT_W'(1);
                            r_issued  <= 1'b0;
                            r_nxt_vld <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_res_vld) begin
                        r_cur    <= mul_res;
                        r_idx    <= r_idx + CNT_W'(1);
                        r_issued <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tf_sched.sv
// Testbench for tf_sched: behavioural parameter store, latency-3 modular
// multiplier and a consumer; expected twiddle streams come from a table.
module tb_tf_sched;
    localparam int DW = 32, MUL_LAT = 3, CNT_W = 12, SW = 4;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [DW-1:0]    modulus;
    logic [SW-1:0]    num_stages;
    logic             busy, done, prm_req, prm_ack, mul_vld, tf_vld, tf_rdy;
    logic [SW-1:0]    prm_stage, tf_stage;
    logic [DW-1:0]    prm_base, prm_step, mul_a, mul_b, mul_mod, mul_res, tf_data;
    logic [CNT_W-1:0] prm_len, tf_idx;

    tf_sched #(.DW(DW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .modulus(modulus), .num_stages(num_stages),
        .busy(busy), .done(done), .prm_req(prm_req), .prm_stage(prm_stage),
        .prm_ack(prm_ack), .prm_base(prm_base), .prm_step(prm_step), .prm_len(prm_len),
        .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
        .mul_res(mul_res), .tf_vld(tf_vld), .tf_rdy(tf_rdy), .tf_data(tf_data),
        .tf_idx(tf_idx), .tf_stage(tf_stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    base;
        logic [DW-1:0]    step;
        logic [CNT_W-1:0] len;
    } prm_t;

    typedef struct {
        int               tid;
        logic [SW-1:0]    stage;
        logic [CNT_W-1:0] idx;
        logic [DW-1:0]    data;
    } exp_t;

    prm_t        cfg [16];
    exp_t        exp_tab [$];
    int          ack_delay;
    int          cyc = 0;
    int          n_checks = 0, n_pass = 0;

    // monitor logs
    logic [47:0]   hs_log [$];
    int            hs_cyc [$];
    logic [SW-1:0] fetch_log [$];
    logic [DW-1:0] mm_log [$];
    int            mul_cnt, done_cnt, done_cyc, req_cnt, busy_cnt, first_req, first_ack;
    int            s_cyc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // latency-MUL_LAT multiplier; drives garbage outside the valid cycle
    initial begin : mul_model
        logic [DW-1:0] pipe [4];
        logic          pv   [4];
        logic [63:0]   prod;
        for (int i = 0; i < 4; i++) begin
            pipe[i] = '0;
            pv[i]   = 1'b0;
        end
        mul_res = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                pipe[i] = pipe[i-1];
                pv[i]   = pv[i-1];
            end
            prod = 64'd0;
            if (mul_vld && mul_mod != 0) prod = (64'(mul_a) * 64'(mul_b)) % 64'(mul_mod);
            pipe[0] = prod[DW-1:0];
            pv[0]   = mul_vld;
            mul_res = pv[3] ? pipe[3] : 32'hDEAD_BEEF;
        end
    end

    // parameter store: acks after ack_delay cycles of prm_req
    initial begin : responder
        int cnt;
        cnt = 0;
        prm_ack = 1'b0; prm_base = '0; prm_step = '0; prm_len = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prm_ack = 1'b0;
                cnt     = 0;
            end else if (prm_ack) begin
                prm_ack = 1'b0;
            end else if (prm_req) begin
                if (cnt >= ack_delay) begin
                    prm_ack  = 1'b1;
                    prm_base = cfg[prm_stage].base;
                    prm_step = cfg[prm_stage].step;
                    prm_len  = cfg[prm_stage].len;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor samples on the falling edge
    initial forever begin
        @(negedge clk);
        if (tf_vld && tf_rdy) begin
            hs_log.push_back({tf_stage, tf_idx, tf_data});
            hs_cyc.push_back(cyc);
            $display("cyc %0d: twiddle stage=%0d idx=%0d data=%0d", cyc, tf_stage, tf_idx, tf_data);
        end
        if (mul_vld) begin
            mul_cnt++;
            mm_log.push_back(mul_mod);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prm_req && prm_ack) begin
            fetch_log.push_back(prm_stage);
            if (first_ack < 0) first_ack = cyc;
        end
        if (prm_req) begin
            req_cnt++;
            if (first_req < 0) first_req = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_logs();
        hs_log.delete(); hs_cyc.delete(); fetch_log.delete(); mm_log.delete();
        mul_cnt = 0; done_cnt = 0; done_cyc = -1; req_cnt = 0; busy_cnt = 0;
        first_req = -1; first_ack = -1;
    endtask

    task automatic add_exp(input int tid, input int stage, input int idx, input int data);
        exp_t e;
        e.tid = tid; e.stage = SW'(stage); e.idx = CNT_W'(idx); e.data = DW'(data);
        exp_tab.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tf_rdy = 1'b0; modulus = '0; num_stages = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic kick(input int q, input int ns);
        modulus    = DW'(q);
        num_stages = SW'(ns);
        start      = 1'b1;
        s_cyc      = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (done_cnt != 0) n_pass++;
        else $display("FAIL %s: done count 0 after %0d cycles, expected a done pulse", name, budget);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_ctrl"}, 64'({busy, done, prm_req, mul_vld, tf_vld}), 64'd0);
        chk({name, "_mul"}, {mul_a, mul_b}, 64'd0);
        chk({name, "_mod_data"}, {mul_mod, tf_data}, 64'd0);
        chk({name, "_idx"}, 64'({prm_stage, tf_idx, tf_stage}), 64'd0);
    endtask

    task automatic check_stream(input int tid);
        int k;
        k = 0;
        foreach (exp_tab[j]) begin
            if (exp_tab[j].tid == tid) begin
                if (k < hs_log.size())
                    chk($sformatf("t%0d_tw%0d", tid, k), 64'(hs_log[k]),
                        64'({exp_tab[j].stage, exp_tab[j].idx, exp_tab[j].data}));
                k++;
            end
        end
        chk($sformatf("t%0d_count", tid), 64'(hs_log.size()), 64'(k));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        // expected twiddle streams {test, stage, idx, data}, q=17
        add_exp(1, 0, 0, 2);  add_exp(1, 0, 1, 6);  add_exp(1, 0, 2, 1);  add_exp(1, 0, 3, 3);
        add_exp(2, 0, 0, 2);  add_exp(2, 0, 1, 6);  add_exp(2, 0, 2, 1);  add_exp(2, 0, 3, 3);
        add_exp(3, 0, 0, 5);  add_exp(3, 0, 1, 10);
        add_exp(3, 2, 0, 3);  add_exp(3, 2, 1, 12); add_exp(3, 2, 2, 14);
        add_exp(5, 0, 0, 7);  add_exp(5, 0, 1, 4);
        add_exp(6, 0, 0, 2);  add_exp(6, 0, 1, 6);  add_exp(6, 0, 2, 1);  add_exp(6, 0, 3, 3);
        for (int i = 0; i < 16; i++) begin
            cfg[i].base = '0; cfg[i].step = '0; cfg[i].len = '0;
        end
        ack_delay = 0;
        clear_logs();

        // reset state
        rst = 1'b1; start = 1'b0; tf_rdy = 1'b0; modulus = 32'd99; num_stages = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        do_reset();

        // 1: single stage, free-running consumer
        cfg[0].base = 2; cfg[0].step = 3; cfg[0].len = 4;
        clear_logs();
        tf_rdy = 1'b1;
        kick(17, 1);
        wait_done("t1_done", 100);
        check_stream(1);
        chk("t1_start_to_req", 64'(first_req - s_cyc), 64'd1);
        if (hs_log.size() == 4) begin
            chk("t1_ack_to_vld", 64'(hs_cyc[0] - first_ack), 64'd1);
            for (int i = 1; i < 4; i++)
                chk($sformatf("t1_spacing%0d", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd4);
            chk("t1_done_lat", 64'(done_cyc - hs_cyc[3]), 64'd1);
        end
        chk("t1_mul_cnt", 64'(mul_cnt), 64'd3);

        // 2: backpressure while idx=1 is presented
        do_reset();
        clear_logs();
        tf_rdy = 1'b1;
        kick(17, 1);
        n = 0;
        while (!(tf_vld && tf_idx == 1) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tf_rdy = 1'b0;
        chk("t2_reach_idx1", 64'(tf_vld && tf_idx == 1), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t2_hold%0d", i), 64'({tf_vld, tf_stage, tf_idx, tf_data}),
                64'({1'b1, 4'd0, 12'd1, 32'd6}));
        end
        chk("t2_mul_cnt_stall", 64'(mul_cnt), 64'd2);
        tf_rdy = 1'b1;
        wait_done("t2_done", 100);
        check_stream(2);

        // 3: three stages, slow parameter store, empty middle stage
        do_reset();
        cfg[0].base = 5; cfg[0].step = 2; cfg[0].len = 2;
        cfg[1].base = 9; cfg[1].step = 9; cfg[1].len = 0;
        cfg[2].base = 3; cfg[2].step = 4; cfg[2].len = 3;
        ack_delay = 5;
        clear_logs();
        tf_rdy = 1'b1;
        kick(17, 3);
        wait_done("t3_done", 400);
        chk("t3_fetch_cnt", 64'(fetch_log.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < fetch_log.size()) chk($sformatf("t3_fetch%0d", i), 64'(fetch_log[i]), 64'(i));
        check_stream(3);
        ack_delay = 0;

        // 4: zero stages
        do_reset();
        clear_logs();
        kick(17, 0);
        wait_done("t4_done", 20);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done_lat", 64'(done_cyc - s_cyc), 64'd1);
        chk("t4_no_req", 64'(req_cnt), 64'd0);
        chk("t4_busy_cycles", 64'(busy_cnt), 64'd1);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);

        // 5: reset one cycle after a multiply issue, stale product must be dropped
        do_reset();
        cfg[0].base = 2; cfg[0].step = 3; cfg[0].len = 4;
        clear_logs();
        tf_rdy = 1'b1;
        kick(17, 1);
        n = 0;
        while (!mul_vld && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_saw_mul", 64'(mul_vld), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("t5_async");
        #1;
        rst = 1'b0;
        cfg[0].base = 7; cfg[0].step = 3; cfg[0].len = 2;
        clear_logs();
        kick(17, 1);
        wait_done("t5_done", 100);
        check_stream(5);

        // 6: start and modulus change while busy are ignored
        do_reset();
        cfg[0].base = 2; cfg[0].step = 3; cfg[0].len = 4;
        clear_logs();
        tf_rdy = 1'b1;
        kick(17, 1);
        repeat (4) @(posedge clk);
        #1;
        modulus = 32'd23; num_stages = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t6_done", 100);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_fetch_cnt", 64'(fetch_log.size()), 64'd1);
        chk("t6_mul_cnt", 64'(mm_log.size()), 64'd3);
        foreach (mm_log[i]) chk($sformatf("t6_mulmod%0d", i), 64'(mm_log[i]), 64'd17);
        check_stream(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
